// File: rtl/regsched_pkg.sv
// Shared types and constants for the Y86-64 register-file write scheduler.
package regsched_pkg;

  localparam logic [3:0]  RNONE    = 4'hF;
  localparam logic [3:0]  RSP      = 4'h4;
  localparam int unsigned NUM_REGS = 15;

  typedef struct packed {
    logic [3:0]  addr;
    logic [63:0] data;
  } wr_entry_t;

endpackage

// File: rtl/regsched_fifo.sv
// Write-entry FIFO: 0/1/2 pushes and 0/1 pop per cycle, registered head view and
// age-ordered entry view for the scoreboard. Data view exists only under REGSCHED_FWD_EN.
module regsched_fifo
  import regsched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push0,
  input  wr_entry_t             push0_entry,
  input  logic                  push1,
  input  wr_entry_t             push1_entry,
  input  logic                  pop,
  output wr_entry_t             head,
  output logic [AW:0]           occupancy,
  output logic [DEPTH-1:0]      view_valid,
  output logic [DEPTH-1:0][3:0] view_addr
`ifdef REGSCHED_FWD_EN
  ,
  output logic [DEPTH-1:0][63:0] view_data
`endif
);

  wr_entry_t     mem_q [DEPTH];
  wr_entry_t     mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   occ_q, occ_d;
  wr_entry_t     out_q, out_d;
  logic [1:0]    npush;

  // push1 is only ever raised together with push0, so it always lands at tail+1.
  // The head register is loaded from the post-update array so a fresh entry is
  // visible on the write port the cycle after it is pushed.
  always_comb begin
    mem_d = mem_q;
    npush = 2'(push0) + 2'(push1);
    if (push0) mem_d[tail_q] = push0_entry;
    if (push1) mem_d[tail_q + AW'(1)] = push1_entry;
    tail_d = tail_q + AW'(npush);
    head_d = head_q + AW'(pop);
    occ_d  = occ_q + (AW+1)'(npush) - (AW+1)'(pop);
    out_d  = (occ_d != '0) ? mem_d[head_d] : out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      out_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      out_q  <= out_d;
      mem_q  <= mem_d;
    end
  end

  // Index 0 is the oldest valid entry.
  always_comb begin
    view_valid = '0;
    view_addr  = '0;
`ifdef REGSCHED_FWD_EN
    view_data  = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      view_valid[i] = ((AW+1)'(i) < occ_q);
      view_addr[i]  = mem_q[head_q + AW'(i)].addr;
`ifdef REGSCHED_FWD_EN
      view_data[i]  = mem_q[head_q + AW'(i)].data;
`endif
    end
  end

  assign head      = out_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/regfile_write_sched.sv
// Serialises E/M writeback pairs onto the single register-file write port and
// exposes a pending-write scoreboard. REGSCHED_FWD_EN selects forwarding over stalling.
module regfile_write_sched
  import regsched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [3:0]              wb_dstE,
  input  logic [63:0]             wb_valE,
  input  logic [3:0]              wb_dstM,
  input  logic [63:0]             wb_valM,
  output logic                    rf_we,
  output logic [3:0]              rf_waddr,
  output logic [63:0]             rf_wdata,
  input  logic [3:0]              rd_srcA,
  input  logic [3:0]              rd_srcB,
  output logic                    rd_stall,
  output logic                    rd_fwdA_valid,
  output logic [63:0]             rd_fwdA_data,
  output logic                    rd_fwdB_valid,
  output logic [63:0]             rd_fwdB_data,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic                  accept;
  logic                  e_en, m_en;
  logic [AW:0]           free_cnt;
  wr_entry_t             slot0, slot1;
  logic                  slot0_v, slot1_v;
  wr_entry_t             head;
  logic [DEPTH-1:0]      view_valid;
  logic [DEPTH-1:0][3:0] view_addr;
  logic [1:0][3:0]       src;
  logic [1:0]            hit;
`ifdef REGSCHED_FWD_EN
  logic [DEPTH-1:0][63:0] view_data;
  logic [1:0][63:0]       fwd_data;
`endif

  // A same-register pair collapses to the M write alone (popq %rsp).
  always_comb begin
    free_cnt     = (AW+1)'(DEPTH) - occupancy;
    wb_ready     = (free_cnt >= (AW+1)'(2));
    accept       = wb_valid && wb_ready;
    e_en         = (wb_dstE != RNONE) && (wb_dstE != wb_dstM);
    m_en         = (wb_dstM != RNONE);
    slot0.addr   = e_en ? wb_dstE : wb_dstM;
    slot0.data   = e_en ? wb_valE : wb_valM;
    slot0_v      = accept && (e_en || m_en);
    slot1.addr   = wb_dstM;
    slot1.data   = wb_valM;
    slot1_v      = accept && e_en && m_en;
  end

  regsched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0       (slot0_v),
    .push0_entry (slot0),
    .push1       (slot1_v),
    .push1_entry (slot1),
    .pop         (rf_we),
    .head        (head),
    .occupancy   (occupancy),
    .view_valid  (view_valid),
    .view_addr   (view_addr)
`ifdef REGSCHED_FWD_EN
    ,
    .view_data   (view_data)
`endif
  );

  assign rf_we    = (occupancy != '0);
  assign rf_waddr = head.addr;
  assign rf_wdata = head.data;

  // Scan oldest to youngest; the last match assigned is the youngest.
`ifdef REGSCHED_FWD_EN
  always_comb begin
    src      = {rd_srcB, rd_srcA};
    hit      = '0;
    fwd_data = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      if (src[s] != RNONE) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (view_valid[i] && (view_addr[i] == src[s])) begin
            hit[s]      = 1'b1;
            fwd_data[s] = view_data[i];
          end
        end
        if (slot0_v && (slot0.addr == src[s])) begin
          hit[s]      = 1'b1;
          fwd_data[s] = slot0.data;
        end
        if (slot1_v && (slot1.addr == src[s])) begin
          hit[s]      = 1'b1;
          fwd_data[s] = slot1.data;
        end
      end
    end
  end

  assign rd_stall      = 1'b0;
  assign rd_fwdA_valid = hit[0];
  assign rd_fwdA_data  = fwd_data[0];
  assign rd_fwdB_valid = hit[1];
  assign rd_fwdB_data  = fwd_data[1];
`else
  always_comb begin
    src = {rd_srcB, rd_srcA};
    hit = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      if (src[s] != RNONE) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (view_valid[i] && (view_addr[i] == src[s])) hit[s] = 1'b1;
        end
        if (slot0_v && (slot0.addr == src[s])) hit[s] = 1'b1;
        if (slot1_v && (slot1.addr == src[s])) hit[s] = 1'b1;
      end
    end
  end

  assign rd_stall      = |hit;
  assign rd_fwdA_valid = 1'b0;
  assign rd_fwdA_data  = '0;
  assign rd_fwdB_valid = 1'b0;
  assign rd_fwdB_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed self-checking bench for regfile_write_sched (DEPTH = 4); forwarding
// expectations switch on REGSCHED_FWD_EN.
module tb_regfile_write_sched;

  localparam int unsigned DEPTH = 4;
  localparam logic [3:0]  NONE  = 4'hF;
  localparam logic [63:0] NEG90 = -64'sd90;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_dstE, wb_dstM;
  logic [63:0] wb_valE, wb_valM;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [3:0]  rd_srcA, rd_srcB;
  logic        rd_stall;
  logic        rd_fwdA_valid, rd_fwdB_valid;
  logic [63:0] rd_fwdA_data, rd_fwdB_data;
  logic [2:0]  occupancy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_write_sched #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_dstE       (wb_dstE),
    .wb_valE       (wb_valE),
    .wb_dstM       (wb_dstM),
    .wb_valM       (wb_valM),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rd_srcA       (rd_srcA),
    .rd_srcB       (rd_srcB),
    .rd_stall      (rd_stall),
    .rd_fwdA_valid (rd_fwdA_valid),
    .rd_fwdA_data  (rd_fwdA_data),
    .rd_fwdB_valid (rd_fwdB_valid),
    .rd_fwdB_data  (rd_fwdB_data),
    .occupancy     (occupancy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    wb_valid = 1'b0;
    wb_dstE  = NONE;
    wb_valE  = '0;
    wb_dstM  = NONE;
    wb_valM  = '0;
  endtask

  task automatic drive_req(input logic [3:0] de, input logic [63:0] ve,
                           input logic [3:0] dm, input logic [63:0] vm);
    wb_valid = 1'b1;
    wb_dstE  = de;
    wb_valE  = ve;
    wb_dstM  = dm;
    wb_valM  = vm;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    rd_srcA = NONE;
    rd_srcB = NONE;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (rf_waddr !== 4'd0) begin n_fail++; $display("FAIL reset_waddr: got %0h expected 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", rf_wdata); end
    n_cmp++; if (rd_fwdA_data !== 64'd0) begin n_fail++; $display("FAIL reset_fwdA_data: got %0h expected 0", rd_fwdA_data); end
    n_cmp++; if (rd_fwdB_data !== 64'd0) begin n_fail++; $display("FAIL reset_fwdB_data: got %0h expected 0", rd_fwdB_data); end
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we c%0d: got %0b expected 0", c, rf_we); end
      n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ c%0d: got %0d expected 0", c, occupancy); end
      n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready c%0d: got %0b expected 1", c, wb_ready); end
      n_cmp++; if (rd_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall c%0d: got %0b expected 0", c, rd_stall); end
      n_cmp++; if ({rd_fwdA_valid, rd_fwdB_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_valid c%0d: got %b expected 00", c, {rd_fwdA_valid, rd_fwdB_valid}); end
      tick();
    end
  endtask

  task automatic test_popq_pair;
    drive_req(4'd4, 64'd40, 4'd3, 64'd7);
    #1;
    n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL pair_ready: got %0b expected 1", wb_ready); end
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL pair_we_k: got %0b expected 0", rf_we); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL pair_we_k1: got %0b expected 1", rf_we); end
    n_cmp++; if (rf_waddr !== 4'd4) begin n_fail++; $display("FAIL pair_addr_k1: got %0h expected 4", rf_waddr); end
    n_cmp++; if (rf_wdata !== 64'd40) begin n_fail++; $display("FAIL pair_data_k1: got %0d expected 40", rf_wdata); end
    n_cmp++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL pair_occ_k1: got %0d expected 2", occupancy); end
    tick();
    n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL pair_we_k2: got %0b expected 1", rf_we); end
    n_cmp++; if (rf_waddr !== 4'd3) begin n_fail++; $display("FAIL pair_addr_k2: got %0h expected 3", rf_waddr); end
    n_cmp++; if (rf_wdata !== 64'd7) begin n_fail++; $display("FAIL pair_data_k2: got %0d expected 7", rf_wdata); end
    n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL pair_occ_k2: got %0d expected 1", occupancy); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL pair_we_k3: got %0b expected 0", rf_we); end
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL pair_occ_k3: got %0d expected 0", occupancy); end
    n_cmp++; if (rf_waddr !== 4'd3) begin n_fail++; $display("FAIL pair_hold_addr: got %0h expected 3", rf_waddr); end
    n_cmp++; if (rf_wdata !== 64'd7) begin n_fail++; $display("FAIL pair_hold_data: got %0d expected 7", rf_wdata); end
  endtask

  task automatic test_popq_rsp;
    drive_req(4'd4, 64'd40, 4'd4, 64'd99);
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL rsp_occ: got %0d expected 1", occupancy); end
    n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL rsp_we: got %0b expected 1", rf_we); end
    n_cmp++; if (rf_waddr !== 4'd4) begin n_fail++; $display("FAIL rsp_addr: got %0h expected 4", rf_waddr); end
    n_cmp++; if (rf_wdata !== 64'd99) begin n_fail++; $display("FAIL rsp_data: got %0d expected 99", rf_wdata); end
    tick();
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rsp_occ_after: got %0d expected 0", occupancy); end
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rsp_we_after: got %0b expected 0", rf_we); end
  endtask

  // Four pair requests held back-to-back: E_r -> (r, 100+r), M_r -> (r+8, 200+r).
  task automatic test_back_to_back;
    int exp_occ [10] = '{0, 2, 3, 2, 3, 2, 3, 2, 1, 0};
    int exp_rdy [7]  = '{1, 1, 0, 1, 0, 1, 0};
    int req = 0;
    int wr  = 0;
    logic acc;
    logic [3:0]  ea;
    logic [63:0] ed;
    for (int c = 0; c < 12; c++) begin
      if (req < 4) drive_req(4'(req), 64'(100 + req), 4'(req + 8), 64'(200 + req));
      else idle_inputs();
      #1;
      if (c < 10) begin
        n_cmp++; if (occupancy !== 3'(exp_occ[c])) begin n_fail++; $display("FAIL b2b_occ c%0d: got %0d expected %0d", c, occupancy, exp_occ[c]); end
      end
      if (c < 7) begin
        n_cmp++; if (wb_ready !== 1'(exp_rdy[c])) begin n_fail++; $display("FAIL b2b_ready c%0d: got %0b expected %0d", c, wb_ready, exp_rdy[c]); end
      end
      if (rf_we === 1'b1) begin
        ea = (wr % 2 == 0) ? 4'(wr / 2) : 4'(wr / 2 + 8);
        ed = (wr % 2 == 0) ? 64'(100 + wr / 2) : 64'(200 + wr / 2);
        n_cmp++; if ({rf_waddr, rf_wdata} !== {ea, ed}) begin n_fail++; $display("FAIL b2b_write%0d: got %0h/%0d expected %0h/%0d", wr, rf_waddr, rf_wdata, ea, ed); end
        wr++;
      end
      acc = wb_valid && wb_ready;
      tick();
      if (acc) req++;
    end
    n_cmp++; if (wr != 8) begin n_fail++; $display("FAIL b2b_write_count: got %0d expected 8", wr); end
    n_cmp++; if (req != 4) begin n_fail++; $display("FAIL b2b_accept_count: got %0d expected 4", req); end
  endtask

  task automatic test_scoreboard;
    int n;
    // Incoming-only hit, then queued hit, then drained.
    drive_req(4'd2, NEG90, NONE, 64'd0);
    rd_srcA = 4'd2;
    rd_srcB = NONE;
    #1;
`ifdef REGSCHED_FWD_EN
    n_cmp++; if (rd_stall !== 1'b0) begin n_fail++; $display("FAIL sb_in_stall: got %0b expected 0", rd_stall); end
    n_cmp++; if (rd_fwdA_valid !== 1'b1) begin n_fail++; $display("FAIL sb_in_fwdA_valid: got %0b expected 1", rd_fwdA_valid); end
    n_cmp++; if (rd_fwdA_data !== NEG90) begin n_fail++; $display("FAIL sb_in_fwdA_data: got %0h expected %0h", rd_fwdA_data, NEG90); end
`else
    n_cmp++; if (rd_stall !== 1'b1) begin n_fail++; $display("FAIL sb_in_stall: got %0b expected 1", rd_stall); end
`endif
    n_cmp++; if (rd_fwdB_valid !== 1'b0) begin n_fail++; $display("FAIL sb_in_fwdB_valid: got %0b expected 0", rd_fwdB_valid); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL sb_q_occ: got %0d expected 1", occupancy); end
`ifdef REGSCHED_FWD_EN
    n_cmp++; if (rd_stall !== 1'b0) begin n_fail++; $display("FAIL sb_q_stall: got %0b expected 0", rd_stall); end
    n_cmp++; if (rd_fwdA_valid !== 1'b1) begin n_fail++; $display("FAIL sb_q_fwdA_valid: got %0b expected 1", rd_fwdA_valid); end
    n_cmp++; if (rd_fwdA_data !== NEG90) begin n_fail++; $display("FAIL sb_q_fwdA_data: got %0h expected %0h", rd_fwdA_data, NEG90); end
`else
    n_cmp++; if (rd_stall !== 1'b1) begin n_fail++; $display("FAIL sb_q_stall: got %0b expected 1", rd_stall); end
    n_cmp++; if (rd_fwdA_valid !== 1'b0) begin n_fail++; $display("FAIL sb_q_fwdA_valid: got %0b expected 0", rd_fwdA_valid); end
`endif
    tick();
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL sb_drain_occ: got %0d expected 0", occupancy); end
    n_cmp++; if (rd_stall !== 1'b0) begin n_fail++; $display("FAIL sb_drain_stall: got %0b expected 0", rd_stall); end
    n_cmp++; if (rd_fwdA_valid !== 1'b0) begin n_fail++; $display("FAIL sb_drain_fwdA_valid: got %0b expected 0", rd_fwdA_valid); end

    // Queue {2,-90},{6,1} with a younger incoming {2,5}.
    rd_srcA = NONE;
    drive_req(4'd2, NEG90, 4'd6, 64'd1);
    tick();
    drive_req(4'd2, 64'd5, NONE, 64'd0);
    rd_srcA = 4'd2;
    rd_srcB = 4'd6;
    #1;
    n_cmp++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL sb_young_occ: got %0d expected 2", occupancy); end
    n_cmp++; if (rf_waddr !== 4'd2) begin n_fail++; $display("FAIL sb_young_head: got %0h expected 2", rf_waddr); end
`ifdef REGSCHED_FWD_EN
    n_cmp++; if (rd_fwdA_data !== 64'd5) begin n_fail++; $display("FAIL sb_young_fwdA_data: got %0h expected 5", rd_fwdA_data); end
    n_cmp++; if (rd_fwdB_valid !== 1'b1) begin n_fail++; $display("FAIL sb_young_fwdB_valid: got %0b expected 1", rd_fwdB_valid); end
    n_cmp++; if (rd_fwdB_data !== 64'd1) begin n_fail++; $display("FAIL sb_young_fwdB_data: got %0h expected 1", rd_fwdB_data); end
    n_cmp++; if (rd_stall !== 1'b0) begin n_fail++; $display("FAIL sb_young_stall: got %0b expected 0", rd_stall); end
`else
    n_cmp++; if (rd_stall !== 1'b1) begin n_fail++; $display("FAIL sb_young_stall: got %0b expected 1", rd_stall); end
`endif
    rd_srcA = NONE;
    rd_srcB = NONE;
    #1;
    n_cmp++; if (rd_stall !== 1'b0) begin n_fail++; $display("FAIL sb_none_stall: got %0b expected 0", rd_stall); end
    n_cmp++; if (rd_fwdA_valid !== 1'b0) begin n_fail++; $display("FAIL sb_none_fwdA_valid: got %0b expected 0", rd_fwdA_valid); end
    tick();
    idle_inputs();
    n = 0;
    while (occupancy !== 3'd0 && n < 8) begin
      tick();
      n++;
    end
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL sb_final_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_reset_mid;
    drive_req(4'd1, 64'd11, 4'd9, 64'd19);
    tick();
    drive_req(4'd2, 64'd22, 4'd10, 64'd20);
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL rstmid_occ_before: got %0d expected 3", occupancy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rstmid_occ: got %0d expected 0", occupancy); end
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we: got %0b expected 0", rf_we); end
    n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %0b expected 1", wb_ready); end
    drive_req(4'd5, 64'd55, NONE, 64'd0);
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_we: got %0b expected 1", rf_we); end
    n_cmp++; if (rf_waddr !== 4'd5) begin n_fail++; $display("FAIL rstmid_new_addr: got %0h expected 5", rf_waddr); end
    n_cmp++; if (rf_wdata !== 64'd55) begin n_fail++; $display("FAIL rstmid_new_data: got %0d expected 55", rf_wdata); end
    n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL rstmid_new_occ: got %0d expected 1", occupancy); end
    tick();
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rstmid_end_occ: got %0d expected 0", occupancy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_popq_pair();
    test_popq_rsp();
    test_back_to_back();
    test_scoreboard();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
